// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory slave.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WADDR,
    WDATA,
    RADDR,
    RDUMMY,
    RSHIFT,
    WAIT_END
  } state_t;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  // Larger of two widths; sizes the shared payload shifter and bit counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM with write enable and registered read.
// Read-during-write returns the previous contents of the addressed word.
module spi_mem_ram #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_mem_slave_param.sv
// Parametrised SPI-slave memory: frames of {dir, cmd[1:0], payload} on MOSI
// (MSB first) under SS_n move addresses/data into an internal RAM and read
// words back out on MISO. Malformed, aborted or out-of-range frames pulse
// frame_err for one cycle.
// Optional burst transfers are built when the macro SPI_MEM_BURST_EN is defined.
module spi_mem_slave_param
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic frame_err
);

`ifdef SPI_MEM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int MAX_W    = max_int(ADDR_W, DATA_W);
  localparam int CNT_W    = $clog2(MAX_W + 1);
  localparam int LAST_INT = MEM_DEPTH - 1;

  localparam logic [CNT_W-1:0]  ADDR_BITS = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_BITS = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = MEM_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_INT[ADDR_W-1:0];

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [MAX_W-1:0]    shift_reg, shift_next;
  logic [DATA_W-1:0]   out_reg, out_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
  logic                dir_reg, dir_next;
  logic                cmd_hi_reg, cmd_hi_next;
  logic                burst_cont_reg, burst_cont_next;
  logic                miso_reg, miso_next;
  logic                err_reg, err_next;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic [CNT_W-1:0]    payload_len;
  logic [ADDR_W-1:0]   payload_addr;
  logic                addr_ok;

  // Next address in a burst, wrapping at the last implemented word.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == LAST_ADDR) begin
      return '0;
    end
    return a + 1'b1;
  endfunction

  assign payload_addr = shift_reg[ADDR_W-1:0];
  assign addr_ok      = ({1'b0, payload_addr} < DEPTH_LIM);
  assign payload_len  = (state_reg == WADDR || state_reg == RADDR) ? ADDR_BITS : DATA_BITS;

  // Frame decoder: next state, payload capture, RAM port control and MISO shifter.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    out_next        = out_reg;
    wr_addr_next    = wr_addr_reg;
    rd_addr_next    = rd_addr_reg;
    dir_next        = dir_reg;
    cmd_hi_next     = cmd_hi_reg;
    burst_cont_next = burst_cont_reg;
    miso_next       = 1'b0;
    err_next        = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = rd_addr_reg;
    ram_wdata       = shift_reg[DATA_W-1:0];

    case (state_reg)
      IDLE: begin
        if (!SS_n) begin
          dir_next        = MOSI;
          cnt_next        = '0;
          burst_cont_next = 1'b0;
          state_next      = CMD;
        end
      end

      CMD: begin
        if (SS_n) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          cmd_hi_next = MOSI;
          cnt_next    = CNT_ONE;
        end else begin
          cnt_next = '0;
          // The direction bit is a redundant copy of cmd[1]; disagreement
          // means the frame is corrupt, so the rest of it is discarded.
          if (dir_reg != cmd_hi_reg) begin
            err_next   = 1'b1;
            state_next = WAIT_END;
          end else begin
            case ({cmd_hi_reg, MOSI})
              CMD_WADDR: state_next = WADDR;
              CMD_WDATA: state_next = WDATA;
              CMD_RADDR: state_next = RADDR;
              CMD_RDATA: state_next = RDUMMY;
              default:   state_next = WAIT_END;
            endcase
          end
        end
      end

      WADDR, WDATA, RADDR, RDUMMY: begin
        if (cnt_reg != payload_len) begin
          if (SS_n) begin
            // Ending a burst cleanly between words is not an error.
            err_next   = !(state_reg == WDATA && burst_cont_reg && cnt_reg == '0);
            state_next = IDLE;
          end else begin
            shift_next = {shift_reg[MAX_W-2:0], MOSI};
            cnt_next   = cnt_reg + 1'b1;
          end
        end else begin
          // Commit cycle: one edge after the last payload bit.
          cnt_next   = '0;
          state_next = SS_n ? IDLE : WAIT_END;
          case (state_reg)
            WADDR: begin
              if (addr_ok) wr_addr_next = payload_addr;
              else         err_next     = 1'b1;
            end
            RADDR: begin
              if (addr_ok) rd_addr_next = payload_addr;
              else         err_next     = 1'b1;
            end
            WDATA: begin
              // Continuation words of a burst go to the following address;
              // a single-word frame leaves wr_addr untouched.
              ram_we = 1'b1;
              if (burst_cont_reg) begin
                ram_addr     = addr_inc(wr_addr_reg);
                wr_addr_next = addr_inc(wr_addr_reg);
              end else begin
                ram_addr = wr_addr_reg;
              end
              if (BURST && !SS_n) begin
                state_next      = WDATA;
                burst_cont_next = 1'b1;
              end
            end
            RDUMMY: begin
              // RAM read of rd_addr is issued on this edge.
              if (!SS_n) state_next = RSHIFT;
            end
            default: ;
          endcase
        end
      end

      RSHIFT: begin
        // While a word shifts out, prefetch the next one for a burst.
        if (BURST && cnt_reg != '0) begin
          ram_addr = addr_inc(rd_addr_reg);
        end
        if (SS_n) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          miso_next = ram_rdata[DATA_W-1];
          out_next  = ram_rdata << 1;
          cnt_next  = CNT_ONE;
        end else if (cnt_reg != DATA_BITS) begin
          miso_next = out_reg[DATA_W-1];
          out_next  = out_reg << 1;
          cnt_next  = cnt_reg + 1'b1;
        end else if (BURST) begin
          miso_next    = ram_rdata[DATA_W-1];
          out_next     = ram_rdata << 1;
          cnt_next     = CNT_ONE;
          rd_addr_next = addr_inc(rd_addr_reg);
        end else begin
          state_next = WAIT_END;
        end
      end

      WAIT_END: begin
        if (SS_n) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      out_reg        <= '0;
      wr_addr_reg    <= '0;
      rd_addr_reg    <= '0;
      dir_reg        <= 1'b0;
      cmd_hi_reg     <= 1'b0;
      burst_cont_reg <= 1'b0;
      miso_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      out_reg        <= out_next;
      wr_addr_reg    <= wr_addr_next;
      rd_addr_reg    <= rd_addr_next;
      dir_reg        <= dir_next;
      cmd_hi_reg     <= cmd_hi_next;
      burst_cont_reg <= burst_cont_next;
      miso_reg       <= miso_next;
      err_reg        <= err_next;
    end
  end

  assign MISO      = miso_reg;
  assign frame_err = err_reg;

  // Reset overrides any write that would otherwise land on this edge.
  spi_mem_ram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we & ~rst),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_spi_mem_slave_param.sv
// Bench for spi_mem_slave_param: a default-size instance (a) and a
// 10-bit address / 16-bit data / 1000-word instance (b) share clk, rst and
// MOSI; sel routes SS_n to one of them and picks its outputs.
module tb_spi_mem_slave_param;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;
  logic ss_n = 1'b1;
  logic sel = 1'b0;
  logic ss_a, ss_b, miso_a, miso_b, err_a, err_b, miso_s, err_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ss_a   = sel ? 1'b1 : ss_n;
  assign ss_b   = sel ? ss_n : 1'b1;
  assign miso_s = sel ? miso_b : miso_a;
  assign err_s  = sel ? err_b : err_a;

  spi_mem_slave_param dut_a (
    .clk(clk), .rst(rst), .MOSI(mosi), .SS_n(ss_a), .MISO(miso_a), .frame_err(err_a)
  );

  spi_mem_slave_param #(.ADDR_W(10), .DATA_W(16), .MEM_DEPTH(1000)) dut_b (
    .clk(clk), .rst(rst), .MOSI(mosi), .SS_n(ss_b), .MISO(miso_b), .frame_err(err_b)
  );

  typedef struct {
    bit          sel;
    logic        dir;
    logic [1:0]  cmd;
    logic [15:0] pl;
    int          exp_err_at;
    bit          rd;
    logic [15:0] exp_word;
  } vec_t;

  vec_t tbl [19];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // One bit period: drive on the falling edge, sample outputs after the rising edge.
  task automatic tick(input logic s, input logic m, output logic mi, output logic er);
    ss_n = s;
    mosi = m;
    @(posedge clk);
    @(negedge clk);
    mi = miso_s;
    er = err_s;
  endtask

  // Full frame: dir, cmd, w payload bits, commit cycle, DATA_W MISO cycles
  // for a read, then one SS_n-high cycle. Returns the read word, the cycle
  // index of the first frame_err (-1 if none) and MISO after the frame.
  task automatic frame(input logic d, input logic [1:0] c, input int w, input logic [15:0] pl,
                       input bit is_read, input int extra,
                       output logic [15:0] word, output int err_at, output logic miso_end);
    logic mi, er, b;
    int total;
    word   = '0;
    err_at = -1;
    total  = is_read ? 4 + 2 * w : 4 + w;
    for (int k = 0; k < total + extra; k++) begin
      if (k == 0)          b = d;
      else if (k == 1)     b = c[1];
      else if (k == 2)     b = c[0];
      else if (k < 3 + w)  b = pl[w - 1 - (k - 3)];
      else                 b = 1'b1;
      tick(1'b0, b, mi, er);
      if (er && err_at < 0) err_at = k;
      if (is_read && k >= 4 + w && k < total) word = {word[14:0], mi};
    end
    tick(1'b1, 1'b0, mi, er);
    if (er && err_at < 0) err_at = total + extra;
    miso_end = mi;
  endtask

  initial begin
    logic [15:0] word;
    logic [23:0] burst_word;
    logic mi, er, me;
    int err_at, w;
    bit any_err;

    tbl[0]  = '{1'b1, 1'b0, CMD_WADDR, 16'd999,  -1, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, CMD_WDATA, 16'hBEEF, -1, 1'b0, 16'h0};
    tbl[2]  = '{1'b1, 1'b1, CMD_RADDR, 16'd999,  -1, 1'b0, 16'h0};
    tbl[3]  = '{1'b1, 1'b1, CMD_RDATA, 16'h0,    -1, 1'b1, 16'hBEEF};
    tbl[4]  = '{1'b1, 1'b0, CMD_WADDR, 16'd1000, 13, 1'b0, 16'h0};
    tbl[5]  = '{1'b1, 1'b0, CMD_WDATA, 16'h1234, -1, 1'b0, 16'h0};
    tbl[6]  = '{1'b1, 1'b1, CMD_RDATA, 16'h0,    -1, 1'b1, 16'h1234};
    tbl[7]  = '{1'b1, 1'b1, CMD_RADDR, 16'd1023, 13, 1'b0, 16'h0};
    tbl[8]  = '{1'b1, 1'b1, CMD_RDATA, 16'h0,    -1, 1'b1, 16'h1234};
    tbl[9]  = '{1'b0, 1'b0, CMD_WADDR, 16'd5,    -1, 1'b0, 16'h0};
    tbl[10] = '{1'b0, 1'b0, CMD_WDATA, 16'h3C,   -1, 1'b0, 16'h0};
    tbl[11] = '{1'b0, 1'b1, CMD_RADDR, 16'd5,    -1, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 1'b0, CMD_RDATA, 16'hFF,    2, 1'b0, 16'h0};
    tbl[13] = '{1'b0, 1'b1, CMD_WDATA, 16'hFF,    2, 1'b0, 16'h0};
    tbl[14] = '{1'b0, 1'b0, CMD_RADDR, 16'd6,     2, 1'b0, 16'h0};
    tbl[15] = '{1'b0, 1'b1, CMD_RDATA, 16'h0,    -1, 1'b1, 16'h3C};
    tbl[16] = '{1'b0, 1'b1, CMD_WADDR, 16'd6,     2, 1'b0, 16'h0};
    tbl[17] = '{1'b0, 1'b0, CMD_WDATA, 16'h5D,   -1, 1'b0, 16'h0};
    tbl[18] = '{1'b0, 1'b1, CMD_RDATA, 16'h0,    -1, 1'b1, 16'h5D};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_miso_a", {31'b0, miso_a}, 0);
    check("reset_err_a",  {31'b0, err_a},  0);
    check("reset_miso_b", {31'b0, miso_b}, 0);
    check("reset_err_b",  {31'b0, err_b},  0);
    rst = 1'b0;
    tick(1'b1, 1'b0, mi, er);

    // Fill addresses 100..199 with 11,22,...,253 repeating, then read back.
    sel = 1'b0;
    any_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      frame(1'b0, CMD_WADDR, 8, 16'(100 + i), 1'b0, 0, word, err_at, me);
      if (err_at >= 0) any_err = 1'b1;
      frame(1'b0, CMD_WDATA, 8, 16'(11 * ((i % 23) + 1)), 1'b0, 0, word, err_at, me);
      if (err_at >= 0) any_err = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      frame(1'b1, CMD_RADDR, 8, 16'(100 + i), 1'b0, 0, word, err_at, me);
      if (err_at >= 0) any_err = 1'b1;
      frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
      if (err_at >= 0) any_err = 1'b1;
      check($sformatf("fill_read_%0d", 100 + i), {16'b0, word}, 32'(11 * ((i % 23) + 1)));
    end
    check("fill_no_frame_err", {31'b0, any_err}, 0);

    // Directed frame table.
    for (int i = 0; i < 19; i++) begin
      sel = tbl[i].sel;
      if (tbl[i].sel) w = (tbl[i].cmd[0]) ? 16 : 10;
      else            w = 8;
      frame(tbl[i].dir, tbl[i].cmd, w, tbl[i].pl, tbl[i].rd, 0, word, err_at, me);
      check($sformatf("vec%0d_err_cycle", i), 32'(err_at), 32'(tbl[i].exp_err_at));
      if (tbl[i].rd) begin
        check($sformatf("vec%0d_word", i), {16'b0, word}, {16'b0, tbl[i].exp_word});
        check($sformatf("vec%0d_miso_idle", i), {31'b0, me}, 0);
      end
    end

    // Abort after 4 of 8 write-data bits: error on the SS_n-high edge, RAM kept.
    sel = 1'b0;
    frame(1'b0, CMD_WADDR, 8, 16'd7, 1'b0, 0, word, err_at, me);
    frame(1'b0, CMD_WDATA, 8, 16'h5A, 1'b0, 0, word, err_at, me);
    any_err = 1'b0;
    tick(1'b0, 1'b0, mi, er); any_err |= er;
    tick(1'b0, 1'b0, mi, er); any_err |= er;
    tick(1'b0, 1'b1, mi, er); any_err |= er;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, mi, er);
      any_err |= er;
    end
    check("abort_no_early_err", {31'b0, any_err}, 0);
    tick(1'b1, 1'b0, mi, er);
    check("abort_err_pulse", {31'b0, er}, 1);
    tick(1'b1, 1'b0, mi, er);
    check("abort_err_one_cycle", {31'b0, er}, 0);
    frame(1'b1, CMD_RADDR, 8, 16'd7, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("abort_ram_kept", {16'b0, word}, 32'h5A);

    // Reset at P5 of a read-data frame.
    frame(1'b0, CMD_WADDR, 8, 16'd0, 1'b0, 0, word, err_at, me);
    frame(1'b0, CMD_WDATA, 8, 16'h77, 1'b0, 0, word, err_at, me);
    frame(1'b0, CMD_WADDR, 8, 16'd9, 1'b0, 0, word, err_at, me);
    frame(1'b0, CMD_WDATA, 8, 16'h99, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RADDR, 8, 16'd9, 1'b0, 0, word, err_at, me);
    tick(1'b0, 1'b1, mi, er);
    tick(1'b0, 1'b1, mi, er);
    tick(1'b0, 1'b1, mi, er);
    tick(1'b0, 1'b0, mi, er);
    tick(1'b0, 1'b0, mi, er);
    rst = 1'b1;
    tick(1'b0, 1'b0, mi, er);
    check("rst_midframe_miso", {31'b0, mi}, 0);
    check("rst_midframe_err", {31'b0, er}, 0);
    rst = 1'b0;
    tick(1'b1, 1'b0, mi, er);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("rst_rd_addr_zero", {16'b0, word}, 32'h77);
    frame(1'b0, CMD_WDATA, 8, 16'h42, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("rst_wr_addr_zero", {16'b0, word}, 32'h42);
    check("rst_following_err", 32'(err_at), 32'hFFFF_FFFF);

`ifdef SPI_MEM_BURST_EN
    // Burst write 0xA1,0xA2,0xA3 from 254, wrapping to 0.
    frame(1'b0, CMD_WADDR, 8, 16'd254, 1'b0, 0, word, err_at, me);
    any_err = 1'b0;
    tick(1'b0, 1'b0, mi, er); any_err |= er;
    tick(1'b0, 1'b0, mi, er); any_err |= er;
    tick(1'b0, 1'b1, mi, er); any_err |= er;
    for (int n = 0; n < 3; n++) begin
      word = 16'(8'hA1 + n);
      for (int k = 7; k >= 0; k--) begin
        tick(1'b0, word[k], mi, er);
        any_err |= er;
      end
      tick(1'b0, 1'b0, mi, er);
      any_err |= er;
    end
    tick(1'b1, 1'b0, mi, er); any_err |= er;
    check("burst_wr_no_err", {31'b0, any_err}, 0);

    // Burst read from 254: three words back to back on MISO.
    frame(1'b1, CMD_RADDR, 8, 16'd254, 1'b0, 0, word, err_at, me);
    any_err = 1'b0;
    burst_word = '0;
    tick(1'b0, 1'b1, mi, er); any_err |= er;
    tick(1'b0, 1'b1, mi, er); any_err |= er;
    tick(1'b0, 1'b1, mi, er); any_err |= er;
    for (int k = 0; k < 9; k++) begin
      tick(1'b0, 1'b0, mi, er);
      any_err |= er;
    end
    for (int k = 0; k < 24; k++) begin
      tick(1'b0, 1'b0, mi, er);
      any_err |= er;
      burst_word = {burst_word[22:0], mi};
    end
    tick(1'b1, 1'b0, mi, er); any_err |= er;
    check("burst_rd_words", {8'b0, burst_word}, 32'hA1A2A3);
    check("burst_rd_miso_idle", {31'b0, mi}, 0);
    check("burst_rd_no_err", {31'b0, any_err}, 0);
    frame(1'b1, CMD_RADDR, 8, 16'd0, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("burst_wrap_ram0", {16'b0, word}, 32'hA3);
`else
    // Trailing bits after a complete write-data frame are ignored.
    frame(1'b0, CMD_WADDR, 8, 16'd20, 1'b0, 0, word, err_at, me);
    frame(1'b0, CMD_WDATA, 8, 16'h11, 1'b0, 9, word, err_at, me);
    check("trailing_no_err", 32'(err_at), 32'hFFFF_FFFF);
    frame(1'b1, CMD_RADDR, 8, 16'd20, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("trailing_ram_kept", {16'b0, word}, 32'h11);
    frame(1'b0, CMD_WDATA, 8, 16'h12, 1'b0, 0, word, err_at, me);
    frame(1'b1, CMD_RDATA, 8, 16'h0, 1'b1, 0, word, err_at, me);
    check("no_auto_increment", {16'b0, word}, 32'h12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
